// File: rtl/snake_move_ctrl.sv
// rtl/snake_move_ctrl.sv - snake head sequencer: move ticks from vsync, direction latch, border collision
module snake_move_ctrl #(
    parameter int FRAMES_PER_MOVE = 8,
    parameter int START_X         = 32,
    parameter int START_Y         = 24
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       start,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [6:0] frame_x_inside_grid,
    input  logic [5:0] frame_y_inside_grid,
    input  logic [6:0] frame_x_size_grid,
    input  logic [5:0] frame_y_size_grid,
    output logic [6:0] head_x,
    output logic [5:0] head_y,
    output logic [1:0] dir,
    output logic       move_tick,
    output logic [1:0] state,
    output logic       game_over
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int CNT_W = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_MOVE - 1);
    localparam logic [6:0] START_X7 = 7'(START_X);
    localparam logic [5:0] START_Y6 = 6'(START_Y);

    state_t           state_q;
    state_t           state_d;
    logic             vsync_d;
    logic             vsync_rise;
    logic             move_now;
    logic [CNT_W-1:0] frame_cnt;
    logic [1:0]       pend;
    logic             req_valid;
    logic [1:0]       req_dir;
    logic             req_ok;
    logic [7:0]       nx;
    logic [6:0]       ny;
    logic [7:0]       x_min;
    logic [7:0]       x_max;
    logic [6:0]       y_min;
    logic [6:0]       y_max;
    logic             next_inside;

    assign vsync_rise = vsync_in & ~vsync_d;
    assign move_now   = (state_q == S_RUN) && vsync_rise && (frame_cnt == CNT_LAST);
    assign state      = state_q;
    assign game_over  = (state_q == S_DEAD);

    always_comb begin
        req_valid = 1'b1;
        req_dir   = DIR_RIGHT;
        if (btn_up)
            req_dir = DIR_UP;
        else if (btn_down)
            req_dir = DIR_DOWN;
        else if (btn_left)
            req_dir = DIR_LEFT;
        else if (btn_right)
            req_dir = DIR_RIGHT;
        else
            req_valid = 1'b0;
    end

    // Opposite directions differ only in bit 0; checked against the committed heading.
    assign req_ok = req_valid && (req_dir != (dir ^ 2'b01));

    // One extra bit so stepping off either edge lands outside the range instead of wrapping.
    always_comb begin
        nx = {1'b0, head_x};
        ny = {1'b0, head_y};
        case (pend)
            DIR_UP:   ny = ny - 7'd1;
            DIR_DOWN: ny = ny + 7'd1;
            DIR_LEFT: nx = nx - 8'd1;
            default:  nx = nx + 8'd1;
        endcase
    end

    assign x_min = {1'b0, frame_x_inside_grid};
    assign x_max = x_min + {1'b0, frame_x_size_grid} - 8'd3;
    assign y_min = {1'b0, frame_y_inside_grid};
    assign y_max = y_min + {1'b0, frame_y_size_grid} - 7'd3;
    assign next_inside = (nx >= x_min) && (nx <= x_max) && (ny >= y_min) && (ny <= y_max);

    always_ff @(posedge pclk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (move_now && !next_inside) state_d = S_DEAD;
            S_DEAD: if (start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            vsync_d   <= 1'b0;
            move_tick <= 1'b0;
            frame_cnt <= '0;
            head_x    <= START_X7;
            head_y    <= START_Y6;
            dir       <= DIR_RIGHT;
            pend      <= DIR_RIGHT;
        end else begin
            vsync_d   <= vsync_in;
            move_tick <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (vsync_rise)
                        frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + CNT_W'(1);
                    if (req_ok)
                        pend <= req_dir;
                    if (move_now) begin
                        dir <= pend;
                        if (next_inside) begin
                            head_x    <= nx[6:0];
                            head_y    <= ny[5:0];
                            move_tick <= 1'b1;
                        end
                    end
                end
                S_DEAD: begin
                    if (start) begin
                        frame_cnt <= '0;
                        head_x    <= START_X7;
                        head_y    <= START_Y6;
                        dir       <= DIR_RIGHT;
                        pend      <= DIR_RIGHT;
                    end
                end
                default: begin
                    frame_cnt <= '0;
                    head_x    <= START_X7;
                    head_y    <= START_Y6;
                    dir       <= DIR_RIGHT;
                    pend      <= DIR_RIGHT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// tb/tb_snake_move_ctrl.sv - self-checking bench for snake_move_ctrl against a cycle-level game model
module tb_snake_move_ctrl;

    localparam int FPM = 8;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync_in = 1'b0;
    logic       start = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [6:0] fxi = 7'd13;
    logic [5:0] fyi = 6'd15;
    logic [6:0] fxs = 7'd40;
    logic [5:0] fys = 6'd20;
    logic [6:0] head_x, head_x1;
    logic [5:0] head_y, head_y1;
    logic [1:0] dir, dir1, state, state1;
    logic       move_tick, move_tick1, game_over, game_over1;

    int tests_run = 0;
    int tests_failed = 0;
    int dut_ticks = 0;
    int dut1_ticks = 0;

    // Behavioural model of the game rules
    int m_x, m_y, m_dir, m_pend, m_state, m_cnt;
    bit m_vsd, m_tick;
    int dx[4] = '{0, 0, -1, 1};
    int dy[4] = '{-1, 1, 0, 0};
    int opp[4] = '{1, 0, 3, 2};

    always #5 pclk = ~pclk;

    snake_move_ctrl #(.FRAMES_PER_MOVE(FPM), .START_X(32), .START_Y(24)) dut (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .start(start),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .frame_x_inside_grid(fxi), .frame_y_inside_grid(fyi),
        .frame_x_size_grid(fxs), .frame_y_size_grid(fys),
        .head_x(head_x), .head_y(head_y), .dir(dir), .move_tick(move_tick),
        .state(state), .game_over(game_over)
    );

    snake_move_ctrl #(.FRAMES_PER_MOVE(1), .START_X(32), .START_Y(24)) dut1 (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .start(start),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .frame_x_inside_grid(fxi), .frame_y_inside_grid(fyi),
        .frame_x_size_grid(fxs), .frame_y_size_grid(fys),
        .head_x(head_x1), .head_y(head_y1), .dir(dir1), .move_tick(move_tick1),
        .state(state1), .game_over(game_over1)
    );

    task automatic model_home();
        m_x = 32; m_y = 24; m_dir = 3; m_pend = 3; m_cnt = 0;
        m_state = 0;
    endtask

    task automatic step(input logic [3:0] b, input logic vs, input logic st);
        int old_dir, req, nx, ny;
        bit rise;
        {btn_up, btn_down, btn_left, btn_right} = b;
        vsync_in = vs;
        start = st;
        rise = vs && !m_vsd;
        m_tick = 0;
        case (m_state)
            0: if (st) begin m_state = 1; m_cnt = 0; end
            1: begin
                old_dir = m_dir;
                req = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : b[0] ? 3 : -1;
                if (rise) begin
                    m_cnt++;
                    if (m_cnt == FPM) begin
                        m_cnt = 0;
                        m_dir = m_pend;
                        nx = m_x + dx[m_pend];
                        ny = m_y + dy[m_pend];
                        if (nx >= int'(fxi) && nx <= int'(fxi) + int'(fxs) - 3 &&
                            ny >= int'(fyi) && ny <= int'(fyi) + int'(fys) - 3) begin
                            m_x = nx; m_y = ny; m_tick = 1;
                        end else begin
                            m_state = 2;
                        end
                    end
                end
                if (req >= 0 && req != opp[old_dir]) m_pend = req;
            end
            default: if (st) model_home();
        endcase
        m_vsd = vs;
        @(posedge pclk);
        #1;
        if (move_tick) dut_ticks++;
        if (move_tick1) dut1_ticks++;
    endtask

    task automatic rises(input int n);
        for (int i = 0; i < n; i++) begin
            step(4'b0000, 1'b1, 1'b0);
            step(4'b0000, 1'b0, 1'b0);
            step(4'b0000, 1'b0, 1'b0);
        end
    endtask

    task automatic press(input logic [3:0] b);
        step(b, 1'b0, 1'b0);
        step(b, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        vsync_in = 1'b0;
        start = 1'b0;
        @(posedge pclk);
        #1;
        rst = 1'b0;
        model_home();
        m_vsd = 0;
        m_tick = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (head_x !== 7'd32 || head_y !== 6'd24) begin
            tests_failed++;
            $display("FAIL reset_head: got (%0d,%0d) want (32,24)", head_x, head_y);
        end
        tests_run++;
        if (dir !== 2'd3 || state !== 2'd0 || move_tick !== 1'b0 || game_over !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: dir=%0d state=%0d tick=%0d go=%0d want 3 0 0 0",
                     dir, state, move_tick, game_over);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        step(4'b0000, 1'b0, 1'b1);
        rises(8);
        press(4'b1000);
        rises(32);
        press(4'b0001);
        rises(56);
        tests_run++;
        if (head_x !== 7'd40 || head_y !== 6'd20 || state !== 2'd1) begin
            tests_failed++;
            $display("FAIL midrun_pos: got (%0d,%0d) st=%0d want (40,20) st=1", head_x, head_y, state);
        end
        do_reset();
        tests_run++;
        if (head_x !== 7'd32 || head_y !== 6'd24 || dir !== 2'd3 || state !== 2'd0 || move_tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_reset: got (%0d,%0d) dir=%0d st=%0d tick=%0d want (32,24) 3 0 0",
                     head_x, head_y, dir, state, move_tick);
        end
    endtask

    task automatic test_run_to_wall();
        do_reset();
        step(4'b0000, 1'b0, 1'b1);
        dut_ticks = 0;
        rises(8);
        tests_run++;
        if (dut_ticks != 1 || head_x !== 7'd33 || head_y !== 6'd24) begin
            tests_failed++;
            $display("FAIL first_move: ticks=%0d head=(%0d,%0d) want 1 (33,24)", dut_ticks, head_x, head_y);
        end
        rises(136);
        tests_run++;
        if (head_x !== 7'd50 || head_y !== 6'd24 || state !== 2'd1 || dut_ticks != 18) begin
            tests_failed++;
            $display("FAIL at_wall: head=(%0d,%0d) st=%0d ticks=%0d want (50,24) 1 18",
                     head_x, head_y, state, dut_ticks);
        end
        rises(8);
        tests_run++;
        if (state !== 2'd2 || game_over !== 1'b1 || head_x !== 7'd50 || dut_ticks != 18) begin
            tests_failed++;
            $display("FAIL wall_death: st=%0d go=%0d x=%0d ticks=%0d want 2 1 50 18",
                     state, game_over, head_x, dut_ticks);
        end
        rises(16);
        tests_run++;
        if (state !== 2'd2 || head_x !== 7'd50 || dut_ticks != 18) begin
            tests_failed++;
            $display("FAIL dead_frozen: st=%0d x=%0d ticks=%0d want 2 50 18", state, head_x, dut_ticks);
        end
    endtask

    task automatic test_no_reverse();
        do_reset();
        step(4'b0000, 1'b0, 1'b1);
        press(4'b0010);
        rises(8);
        tests_run++;
        if (head_x !== 7'd33 || head_y !== 6'd24 || dir !== 2'd3) begin
            tests_failed++;
            $display("FAIL reverse_drop: head=(%0d,%0d) dir=%0d want (33,24) 3", head_x, head_y, dir);
        end
        press(4'b1000);
        rises(8);
        tests_run++;
        if (head_x !== 7'd33 || head_y !== 6'd23 || dir !== 2'd0) begin
            tests_failed++;
            $display("FAIL turn_up: head=(%0d,%0d) dir=%0d want (33,23) 0", head_x, head_y, dir);
        end
        press(4'b0100);
        rises(8);
        tests_run++;
        if (head_x !== 7'd33 || head_y !== 6'd22 || dir !== 2'd0) begin
            tests_failed++;
            $display("FAIL reverse_drop_up: head=(%0d,%0d) dir=%0d want (33,22) 0", head_x, head_y, dir);
        end
    endtask

    task automatic test_priority_top_wall();
        do_reset();
        step(4'b0000, 1'b0, 1'b1);
        press(4'b1010);
        rises(8);
        tests_run++;
        if (head_x !== 7'd32 || head_y !== 6'd23 || dir !== 2'd0) begin
            tests_failed++;
            $display("FAIL priority_up: head=(%0d,%0d) dir=%0d want (32,23) 0", head_x, head_y, dir);
        end
        rises(64);
        tests_run++;
        if (head_y !== 6'd15 || state !== 2'd1) begin
            tests_failed++;
            $display("FAIL top_row: y=%0d st=%0d want 15 1", head_y, state);
        end
        rises(8);
        tests_run++;
        if (head_y !== 6'd15 || head_x !== 7'd32 || state !== 2'd2 || game_over !== 1'b1) begin
            tests_failed++;
            $display("FAIL top_death: head=(%0d,%0d) st=%0d go=%0d want (32,15) 2 1",
                     head_x, head_y, state, game_over);
        end
    endtask

    task automatic test_dead_restart();
        step(4'b0000, 1'b0, 1'b1);
        tests_run++;
        if (state !== 2'd0 || game_over !== 1'b0 || head_x !== 7'd32 || head_y !== 6'd24 || dir !== 2'd3) begin
            tests_failed++;
            $display("FAIL dead_to_idle: st=%0d go=%0d head=(%0d,%0d) dir=%0d want 0 0 (32,24) 3",
                     state, game_over, head_x, head_y, dir);
        end
        step(4'b0000, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        tests_run++;
        if (state !== 2'd1) begin
            tests_failed++;
            $display("FAIL idle_to_run: st=%0d want 1", state);
        end
        dut_ticks = 0;
        rises(7);
        tests_run++;
        if (dut_ticks != 0 || head_x !== 7'd32) begin
            tests_failed++;
            $display("FAIL early_move: ticks=%0d x=%0d want 0 32", dut_ticks, head_x);
        end
        rises(1);
        tests_run++;
        if (dut_ticks != 1 || head_x !== 7'd33) begin
            tests_failed++;
            $display("FAIL restart_move: ticks=%0d x=%0d want 1 33", dut_ticks, head_x);
        end
    endtask

    task automatic test_vsync_held();
        do_reset();
        step(4'b0000, 1'b0, 1'b1);
        dut1_ticks = 0;
        for (int i = 0; i < 100; i++) step(4'b0000, 1'b1, 1'b0);
        tests_run++;
        if (dut1_ticks != 1 || head_x1 !== 7'd33 || head_y1 !== 6'd24) begin
            tests_failed++;
            $display("FAIL vsync_held: ticks=%0d head=(%0d,%0d) want 1 (33,24)", dut1_ticks, head_x1, head_y1);
        end
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 1'b0, 1'b0);
            step(4'b0000, 1'b1, 1'b0);
        end
        tests_run++;
        if (dut1_ticks != 6 || head_x1 !== 7'd38 || dir1 !== 2'd3 || state1 !== 2'd1 || game_over1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL vsync_toggle: ticks=%0d x=%0d dir=%0d st=%0d go=%0d want 6 38 3 1 0",
                     dut1_ticks, head_x1, dir1, state1, game_over1);
        end
    endtask

    task automatic test_random();
        logic [3:0] b;
        logic vs, st;
        int errs;
        do_reset();
        step(4'b0000, 1'b0, 1'b1);
        b = 4'b0000;
        vs = 1'b0;
        errs = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) b = 4'($urandom_range(0, 15));
            vs = ($urandom_range(0, 2) == 0) ? ~vs : vs;
            st = ($urandom_range(0, 150) == 0);
            if (vs && !m_vsd) step(4'b0000, vs, st);
            else step(b, vs, st);
            tests_run++;
            if (head_x !== 7'(m_x) || head_y !== 6'(m_y) || dir !== 2'(m_dir) ||
                state !== 2'(m_state) || move_tick !== m_tick || game_over !== (m_state == 2)) begin
                tests_failed++;
                if (errs < 10)
                    $display("FAIL random_cycle%0d: head=(%0d,%0d) dir=%0d st=%0d tick=%0d want (%0d,%0d) %0d %0d %0d",
                             i, head_x, head_y, dir, state, move_tick, m_x, m_y, m_dir, m_state, m_tick);
                errs++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_run_to_wall();
        test_no_reverse();
        test_priority_top_wall();
        test_dead_restart();
        test_vsync_held();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
